mema_feed_sequencer: RTL and testbench
======================================

// Module: mema_feed_sequencer
// PURPOSE
//  Sequencer for the systolic A-input memory (skewed row-to-column transpose FIFOs).
//  - Accepts DIM rows of A over a valid/ready stream.
//  - Writes each row into the memory: a_wren, row index on a_row.
//  - Then asserts a_en long enough to push every skewed column through the MAC array and drain it.
//  - Reports busy/done to the top-level TPU controller.
// PARAMETERS
//  BITS_AB  8   element width of A (signed)
//  DIM      8   array dimension; rows per matrix and elements per row
// PORTS
//  clk          in   1               clock; all logic on posedge
//  rst          in   1               async active-high reset
//  start        in   1               single-cycle request to begin one A-matrix transaction
//  row_valid    in   1               row_data holds a valid row
//  row_ready    out  1               sequencer accepts a row this cycle
//  row_data     in   BITS_AB x DIM   signed row, element [DIM-1] = column 0
//  a_en         out  1               shift enable to A memory
//  a_wren       out  1               row write enable to A memory
//  a_row        out  $clog2(DIM)     row index being written
//  a_data       out  BITS_AB x DIM   registered copy of accepted row_data
//  mac_en       out  1               MAC array enable; a_en delayed 1 cycle (memory output latency)
//  mac_clr      out  1               one-cycle accumulator clear, first STREAM cycle
//  busy         out  1               high in any state except IDLE
//  done         out  1               one-cycle pulse when transaction completes
// BEHAVIOUR
//  - Reset: state=IDLE. row_ready, a_en, a_wren, mac_en, mac_clr, busy and done are 0.
//    a_row and a_data are 0. Reset asserted mid-transaction aborts immediately; no done pulse.
//  - States: IDLE -> LOAD -> STREAM -> DONE -> IDLE. Encoding is the package enum.
//  - IDLE: row_ready=0. start=1 -> LOAD next cycle; row counter and stream counter cleared.
//  - LOAD: row_ready=1.
//    - Handshake is row_valid & row_ready. On it, in the next cycle: a_wren=1, a_en=0,
//      a_row=row counter, a_data=row_data. Then row counter +1.
//    - row_valid low: hold the counter; a_wren=0.
//    - Handshake with row counter == DIM-1 -> STREAM. row_ready drops the same edge.
//      At most DIM rows are ever accepted.
//  - STREAM: a_en=1 for exactly STREAM_CYCLES = 3*DIM-2 consecutive cycles (counter 0..3*DIM-3).
//    - Covers skew fill, DIM columns and drain.
//    - mac_clr=1 on stream count 0 only.
//    - The final a_wren from LOAD and the first a_en never coincide; a one-cycle gap is allowed.
//  - DONE: done=1 and busy=1 for one cycle -> IDLE.
//  - mac_en mirrors a_en delayed by one register stage. It therefore stays high one cycle into DONE.
//  - start outside IDLE is ignored (no queueing).
//  - start and reset in the same cycle: reset wins.
//  - All outputs are registered. a_row width is $clog2(DIM); the counter wraps at DIM-1 -> 0.
//  - DIM must be >= 2.
// CONFIGURATION
//  MEMA_SEQ_PERF_EN
//  - Defined: extra output perf_stall_cnt [15:0]. It counts LOAD cycles with row_valid=0,
//    cleared on start, saturates at 16'hFFFF, reset to 0, and is held after DONE until the next start.
//  - Undefined: the port and counter are absent. Behaviour is otherwise identical.
// STRUCTURE
//  - Package mema_seq_pkg:
//    - typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} mema_seq_state_t
//    - localparam function stream_cycles(DIM)
//    - typedef for the row array type
//  - One sub-module: mema_seq_counter, a parameterised-width up-counter with clear, enable,
//    terminal-count flag and optional saturation. Used for the row, stream and perf counters.
// TESTING
//  1. DIM=8, start, 8 back-to-back valid rows, element value = 10*row+col
//     -> a_wren pulses 8 cycles, a_row 0..7, a_data matches, a_en high 22 cycles,
//     done one pulse, busy falls after done.
//  2. row_valid toggles 1/0 during LOAD -> a_row increments only on handshakes; 8 writes total.
//     With MEMA_SEQ_PERF_EN, perf_stall_cnt = number of low-valid cycles.
//  3. start pulsed during LOAD and during STREAM -> ignored; exactly one done; a_en count still 22.
//  4. rst asserted at stream count 5 -> all outputs 0 within the reset cycle, no done.
//     A new start runs a full clean transaction.
//  5. mac_en equals a_en delayed 1 cycle over the whole run; mac_clr high exactly once,
//     aligned with the first a_en.
//  6. DIM=2 build -> 2 writes, a_en high 4 cycles, done pulse.

Source files
------------

// File: rtl/mema_seq_pkg.sv
// -----------------------------------------------------------------------------
// mema_seq_pkg
// Shared types and helpers for the systolic A-input memory feed sequencer.
//   mema_seq_state_t : sequencer FSM encoding (IDLE -> LOAD -> STREAM -> DONE)
//   mema_elem_t      : one signed A element at the default element width
//   mema_row_t       : one row of A at the default width and dimension
//   stream_cycles()  : number of a_en cycles needed to fill the skew, shift
//                      DIM columns and drain the array (3*DIM-2)
// -----------------------------------------------------------------------------
package mema_seq_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      STREAM = 2'd2,
      DONE   = 2'd3
   } mema_seq_state_t;

   localparam int BITS_AB_DEF = 8;
   localparam int DIM_DEF     = 8;

   typedef logic signed [BITS_AB_DEF-1:0] mema_elem_t;
   // Element [DIM-1] is column 0.
   typedef mema_elem_t [DIM_DEF-1:0]      mema_row_t;

   // Skew fill (DIM-1) + DIM columns + drain (DIM-1).
   function automatic int stream_cycles(input int dim);
      return 3 * dim - 2;
   endfunction

endpackage : mema_seq_pkg

// File: rtl/mema_seq_counter.sv
// -----------------------------------------------------------------------------
// mema_seq_counter
// Parameterised up-counter with synchronous clear, enable and terminal-count
// flag. At MAX_VAL it either wraps to 0 or holds, depending on SATURATE.
// Ports:
//   clk     in   clock, posedge
//   rst     in   async active-high reset, counter -> 0
//   i_clr   in   synchronous clear, wins over i_en
//   i_en    in   count enable
//   o_cnt   out  [WIDTH-1:0] current count
//   o_tc    out  high while o_cnt == MAX_VAL
// -----------------------------------------------------------------------------
module mema_seq_counter #(
   parameter int               WIDTH    = 4,
   parameter logic [WIDTH-1:0] MAX_VAL  = '1,
   parameter bit               SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_en,
   output logic [WIDTH-1:0] o_cnt,
   output logic             o_tc
);

   logic [WIDTH-1:0] r_cnt;

   assign o_tc  = (r_cnt == MAX_VAL);
   assign o_cnt = r_cnt;

   // NOTE: clocked state is written with <= only, so every register samples
   // the pre-edge values of the others regardless of block ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         if (!o_tc) begin
            r_cnt <= r_cnt + 1'b1;
         end else if (!SATURATE) begin
            r_cnt <= '0;
         end
      end
   end

endmodule : mema_seq_counter

// File: rtl/mema_feed_sequencer.sv
// -----------------------------------------------------------------------------
// mema_feed_sequencer
// Sequencer for the systolic A-input memory (skewed row-to-column transpose
// FIFOs). Accepts DIM rows of A over a valid/ready stream, writes each row
// into the memory, then shifts the memory for 3*DIM-2 cycles so every skewed
// column passes through the MAC array and drains. All outputs are registered.
//
// Optional feature macro: MEMA_SEQ_PERF_EN adds perf_stall_cnt[15:0], the
// number of LOAD cycles with row_valid low (cleared on start, saturating).
//
// Ports:
//   clk, rst        clock (posedge) and async active-high reset
//   start           single-cycle request, honoured only in IDLE
//   row_valid/ready row stream handshake; row_data element [DIM-1] = column 0
//   a_wren, a_row   row write strobe and row index to the A memory
//   a_data          registered copy of the accepted row
//   a_en            A memory shift enable
//   mac_en          a_en delayed one cycle (memory output latency)
//   mac_clr         accumulator clear, aligned with the first a_en
//   busy, done      status to the TPU controller; done is a one-cycle pulse
// -----------------------------------------------------------------------------
module mema_feed_sequencer
   import mema_seq_pkg::*;
#(
   parameter int BITS_AB = 8,
   parameter int DIM     = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic                             row_valid,
   output logic                             row_ready,
   input  logic [DIM-1:0][BITS_AB-1:0]      row_data,
   output logic                             a_en,
   output logic                             a_wren,
   output logic [$clog2(DIM)-1:0]           a_row,
   output logic [DIM-1:0][BITS_AB-1:0]      a_data,
   output logic                             mac_en,
   output logic                             mac_clr,
   output logic                             busy,
   output logic                             done
`ifdef MEMA_SEQ_PERF_EN
   ,
   output logic [15:0]                      perf_stall_cnt
`endif
);

   localparam int SC = stream_cycles(DIM);
   localparam int RW = $clog2(DIM);
   localparam int SW = $clog2(SC);

   mema_seq_state_t r_state;
   mema_seq_state_t w_state_nxt;

   logic                        r_row_ready;
   logic                        r_a_en;
   logic                        r_a_wren;
   logic [RW-1:0]               r_a_row;
   logic [DIM-1:0][BITS_AB-1:0] r_a_data;
   logic                        r_mac_en;
   logic                        r_mac_clr;
   logic                        r_busy;
   logic                        r_done;

   logic          w_start;
   logic          w_hs;
   logic [RW-1:0] w_row_cnt;
   logic          w_row_tc;
   logic [SW-1:0] w_stream_cnt;
   logic          w_stream_tc;

   assign w_start = start && (r_state == IDLE);
   assign w_hs    = row_valid && r_row_ready;

   // Row index: advances on each accepted row, wraps DIM-1 -> 0.
   mema_seq_counter #(
      .WIDTH    (RW),
      .MAX_VAL  (RW'(DIM - 1)),
      .SATURATE (1'b0)
   ) u_row_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_clr (w_start),
      .i_en  (w_hs),
      .o_cnt (w_row_cnt),
      .o_tc  (w_row_tc)
   );

   // Stream count: advances once per a_en cycle, so its value equals the
   // index of the a_en cycle currently on the output.
   mema_seq_counter #(
      .WIDTH    (SW),
      .MAX_VAL  (SW'(SC - 1)),
      .SATURATE (1'b0)
   ) u_stream_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_clr (w_start),
      .i_en  (r_a_en),
      .o_cnt (w_stream_cnt),
      .o_tc  (w_stream_tc)
   );

`ifdef MEMA_SEQ_PERF_EN
   logic w_perf_tc;

   mema_seq_counter #(
      .WIDTH    (16),
      .MAX_VAL  (16'hFFFF),
      .SATURATE (1'b1)
   ) u_perf_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_clr (w_start),
      .i_en  ((r_state == LOAD) && !row_valid && !w_perf_tc),
      .o_cnt (perf_stall_cnt),
      .o_tc  (w_perf_tc)
   );
`endif

   // NOTE: w_state_nxt gets a default before the case, so no path through the
   // block leaves it unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (start) w_state_nxt = LOAD;
         LOAD:    if (w_hs && w_row_tc) w_state_nxt = STREAM;
         // Leave after the last a_en cycle has been issued.
         STREAM:  if (r_a_en && w_stream_tc) w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // NOTE: a_data is a datapath register but is still reset, so the memory
   // interface sees defined zeros after reset rather than stale or X data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_row_ready <= 1'b0;
         r_a_en      <= 1'b0;
         r_a_wren    <= 1'b0;
         r_a_row     <= '0;
         r_a_data    <= '0;
         r_mac_en    <= 1'b0;
         r_mac_clr   <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         // Status outputs follow the next state so they line up with it.
         r_row_ready <= (w_state_nxt == LOAD);
         r_busy      <= (w_state_nxt != IDLE);
         r_done      <= (w_state_nxt == DONE);
         r_a_wren    <= w_hs;
         if (w_hs) begin
            r_a_row  <= w_row_cnt;
            r_a_data <= row_data;
         end
         // The first STREAM cycle is a gap so the last row write and the
         // first shift never land in the same cycle.
         r_a_en      <= (r_state == STREAM) && (w_state_nxt == STREAM);
         r_mac_clr   <= (r_state == STREAM) && !r_a_en;
         r_mac_en    <= r_a_en;
      end
   end

   assign row_ready = r_row_ready;
   assign a_en      = r_a_en;
   assign a_wren    = r_a_wren;
   assign a_row     = r_a_row;
   assign a_data    = r_a_data;
   assign mac_en    = r_mac_en;
   assign mac_clr   = r_mac_clr;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule : mema_feed_sequencer

// File: tb/tb_mema_feed_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mema_feed_sequencer
// Directed bench for mema_feed_sequencer with a DIM=8 and a DIM=2 instance.
// Expected per-cycle outputs come from the transaction timeline measured from
// the start edge: with L the offset of the cycle after the last accepted row,
// a_en is high on L+1..L+3*DIM-2, mac_clr on L+1, mac_en one cycle after a_en,
// done on L+3*DIM-1, busy from the start edge through the done cycle.
// Optional feature macro: MEMA_SEQ_PERF_EN (checks perf_stall_cnt).
// -----------------------------------------------------------------------------
module tb_mema_feed_sequencer;

   logic clk;
   logic rst;

   logic            start8, valid8, ready8, aen8, wren8, men8, clr8, busy8, done8;
   logic [7:0][7:0] data8, adata8;
   logic [2:0]      row8;

   logic            start2, valid2, ready2, aen2, wren2, men2, clr2, busy2, done2;
   logic [1:0][7:0] data2, adata2;
   logic [0:0]      row2;

`ifdef MEMA_SEQ_PERF_EN
   logic [15:0] perf8, perf2;
`endif

   int n_pass  = 0;
   int n_total = 0;

   mema_feed_sequencer #(.BITS_AB(8), .DIM(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .row_valid(valid8), .row_ready(ready8),
      .row_data(data8), .a_en(aen8), .a_wren(wren8), .a_row(row8), .a_data(adata8),
      .mac_en(men8), .mac_clr(clr8), .busy(busy8), .done(done8)
`ifdef MEMA_SEQ_PERF_EN
      , .perf_stall_cnt(perf8)
`endif
   );

   mema_feed_sequencer #(.BITS_AB(8), .DIM(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .row_valid(valid2), .row_ready(ready2),
      .row_data(data2), .a_en(aen2), .a_wren(wren2), .a_row(row2), .a_data(adata2),
      .mac_en(men2), .mac_clr(clr2), .busy(busy2), .done(done2)
`ifdef MEMA_SEQ_PERF_EN
      , .perf_stall_cnt(perf2)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   // {row_ready, a_wren, a_en, mac_en, mac_clr, busy, done}
   function automatic logic [6:0] flags(input bit s2);
      if (s2) return {ready2, wren2, aen2, men2, clr2, busy2, done2};
      return {ready8, wren8, aen8, men8, clr8, busy8, done8};
   endfunction

   function automatic logic [63:0] obs_row(input bit s2);
      return s2 ? 64'(row2) : 64'(row8);
   endfunction

   function automatic logic [63:0] obs_data(input bit s2);
      return s2 ? 64'(adata2) : 64'(adata8);
   endfunction

   // Element value 10*row+col; column c sits at element index dim-1-c.
   function automatic logic [63:0] row_val(input int dim, input int r);
      logic [63:0] v;
      v = '0;
      for (int c = 0; c < dim; c++) v[(dim-1-c)*8 +: 8] = 8'(10*r + c);
      return v;
   endfunction

   task automatic drive(input bit s2, input logic st, input logic v, input logic [63:0] d);
      if (s2) begin
         start2 = st; valid2 = v; data2 = d[15:0];
      end else begin
         start8 = st; valid8 = v; data8 = d;
      end
   endtask

   // Runs one transaction from IDLE, checking every cycle against the
   // timeline. vpat bit k is row_valid during cycle k after the start edge.
   task automatic run_txn(input string tag, input bit s2, input int dim,
                          input logic [63:0] vpat, input int poke_a,
                          input int poke_b, input int abort_at);
      int   sc;
      int   l_ofs;
      int   rows;
      int   prev_idx;
      int   stalls;
      bit   prev_hs;
      bit   finished;
      logic [6:0] exp_f;
      sc = 3*dim - 2; l_ofs = -1; rows = 0; prev_idx = 0; stalls = 0;
      prev_hs = 1'b0; finished = 1'b0;
      drive(s2, 1'b1, 1'b0, '0);
      @(negedge clk);
      for (int k = 0; k < 200 && !finished; k++) begin
         bit rr, v, hs;
         rr    = (l_ofs < 0);
         exp_f = {rr, prev_hs,
                  (l_ofs >= 0 && k >= l_ofs+1 && k <= l_ofs+sc),
                  (l_ofs >= 0 && k >= l_ofs+2 && k <= l_ofs+sc+1),
                  (l_ofs >= 0 && k == l_ofs+1),
                  (l_ofs < 0 || k <= l_ofs+sc+1),
                  (l_ofs >= 0 && k == l_ofs+sc+1)};
         check($sformatf("%s k=%0d flags", tag, k), 64'(flags(s2)), 64'(exp_f));
         if (prev_hs) begin
            check($sformatf("%s k=%0d a_row", tag, k), obs_row(s2), 64'(prev_idx));
            check($sformatf("%s k=%0d a_data", tag, k), obs_data(s2), row_val(dim, prev_idx));
         end
         if (k == abort_at) begin
            rst = 1'b1;
            #1;
            check($sformatf("%s rst flags", tag), 64'(flags(s2)), 64'd0);
            check($sformatf("%s rst a_row", tag), obs_row(s2), 64'd0);
            check($sformatf("%s rst a_data", tag), obs_data(s2), 64'd0);
            drive(s2, 1'b0, 1'b0, '0);
            @(negedge clk);
            check($sformatf("%s rst no done", tag), 64'(flags(s2)), 64'd0);
            rst = 1'b0;
            @(negedge clk);
            return;
         end
         if (l_ofs >= 0 && k == l_ofs+sc+2) begin
            finished = 1'b1;
         end else begin
            v  = (k < 64) ? vpat[k] : 1'b0;
            hs = v && rr;
            prev_hs  = hs;
            prev_idx = rows;
            if (rr && !v) stalls++;
            drive(s2, (k == poke_a || k == poke_b), v, row_val(dim, (rows < dim) ? rows : 0));
            if (hs) begin
               rows++;
               if (rows == dim) l_ofs = k + 1;
            end
            @(negedge clk);
         end
      end
      check($sformatf("%s completed", tag), 64'(finished), 64'd1);
`ifdef MEMA_SEQ_PERF_EN
      check($sformatf("%s perf_stall_cnt", tag), s2 ? 64'(perf2) : 64'(perf8), 64'(stalls));
`endif
      drive(s2, 1'b0, 1'b0, '0);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, '0);
      drive(1'b1, 1'b0, 1'b0, '0);
      repeat (2) @(negedge clk);

      // Reset state of both instances.
      check("reset flags dim8", 64'(flags(1'b0)), 64'd0);
      check("reset a_row dim8", obs_row(1'b0), 64'd0);
      check("reset a_data dim8", obs_data(1'b0), 64'd0);
      check("reset flags dim2", 64'(flags(1'b1)), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // Back-to-back rows; valid stays high after row 7 (no 9th accept).
      run_txn("t1_b2b", 1'b0, 8, 64'hFFFF_FFFF_FFFF_FFFF, -1, -1, -1);
      // Toggling valid, first cycle valid then first cycle stalled.
      run_txn("t2_toggle_a", 1'b0, 8, 64'h5555_5555_5555_5555, -1, -1, -1);
      run_txn("t2_toggle_b", 1'b0, 8, 64'hAAAA_AAAA_AAAA_AAAA, -1, -1, -1);
      // start pulses during LOAD (k=3) and STREAM (k=15) are ignored.
      run_txn("t3_start_ign", 1'b0, 8, 64'hFFFF_FFFF_FFFF_FFFF, 3, 15, -1);
      // Reset at stream count 5 (cycle 9+5), then a clean transaction.
      run_txn("t4_abort", 1'b0, 8, 64'hFFFF_FFFF_FFFF_FFFF, -1, -1, 14);
      run_txn("t4_after", 1'b0, 8, 64'hFFFF_FFFF_FFFF_FFFF, -1, -1, -1);

      // start and reset together: reset wins, sequencer stays idle.
      rst = 1'b1;
      start8 = 1'b1;
      @(negedge clk);
      check("rst_start flags", 64'(flags(1'b0)), 64'd0);
      start8 = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      check("rst_start idle", 64'(flags(1'b0)), 64'd0);

      // DIM=2 instance: 2 writes, 4 a_en cycles, done.
      run_txn("t6_dim2", 1'b1, 2, 64'hFFFF_FFFF_FFFF_FFFF, -1, -1, -1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_mema_feed_sequencer
